jump_field_encoder: RTL

Buffered encoder that converts a 32-bit jump target address into a MIPS J-type instruction word (`j` or `jal`), the inverse of the datapath's jump-target formation `{PC+4[31:28], field, 2'b00}`. It sits between the program loader/assembler front end and instruction memory write logic. Requests use a valid/ready handshake, and results pass through a 2-entry output FIFO. Each request is checked for alignment and for 256 MB region reachability.

---
 rtl/jump_field_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/jump_field_encoder.sv
// jump_field_encoder: turns a jump target byte address into a MIPS J-type
// word (j / jal) and buffers the result in a 2-entry output FIFO.
// Each result also carries two error flags: a misaligned target, and a
// target outside the 256 MB region of PC+4.
// Optional feature macro: JUMP_ENC_ERRCNT_EN adds the saturating err_count
// output, which counts accepted requests whose error flags are nonzero.
module jump_field_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_target,
  input  logic        in_link,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err
`ifdef JUMP_ENC_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // FIFO storage: each entry is {instr, err}
  logic [33:0] r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  // Head copy driving the outputs; it keeps the last value while empty
  logic [33:0] r_head;

  logic [31:0] w_pc4;
  logic [1:0]  w_err;
  logic [31:0] w_instr;
  logic        w_push;
  logic        w_pop;
  logic        w_rptr_next;
  logic [1:0]  w_count_next;
  logic [33:0] w_head_next;

  // The ready and valid flags come from registered occupancy only
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_head[33:2];
  assign out_err   = r_head[1:0];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Encode the request and flag alignment and region errors
  always_comb begin
    w_pc4    = in_pc + 32'd4;
    w_err    = {(in_target[31:28] != w_pc4[31:28]), (|in_target[1:0])};
    w_instr  = {(in_link ? OP_JAL : OP_J), in_target[27:2]};
    if (w_err != 2'b00) begin
      w_instr = 32'h0;
    end
  end

  // Work out the next occupancy and the entry that will be at the head
  always_comb begin
    w_rptr_next  = r_rptr ^ w_pop;
    w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // A push into the slot that becomes the head is forwarded straight
    // through, because that slot is only written at this same edge
    if (w_push && (r_wptr == w_rptr_next)) begin
      w_head_next = {w_instr, w_err};
    end else begin
      w_head_next = r_mem[w_rptr_next];
    end
  end

  // Update the FIFO storage, the pointers, the occupancy and the head register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_instr, w_err};
      end
      r_wptr  <= r_wptr ^ w_push;
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      if (w_count_next != 2'd0) begin
        r_head <= w_head_next;
      end
    end
  end

`ifdef JUMP_ENC_ERRCNT_EN
  logic [7:0] r_err_count;

  assign err_count = r_err_count;

  // Count accepted erroneous requests at the accepting edge; saturates at 8'hFF
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_count <= 8'h00;
    end else if (w_push && (w_err != 2'b00) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end
`endif

endmodule
